// File: rtl/square_period_detector.sv
// Recovers the note period of a signed sample stream by timing successive
// negative-to-positive crossings, with a hysteresis band to reject noise.
module square_period_detector #(
    parameter int THRESH     = 100000000,
    parameter int MIN_PERIOD = 16,
    parameter int MAX_PERIOD = 2000000,
    parameter int TOL        = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        sample_en,
    input  logic [31:0] audio_in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        note_present,
    output logic        locked
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE
    } state_t;

    localparam logic signed [31:0] POS_LIMIT = THRESH;
    localparam logic signed [31:0] NEG_LIMIT = -THRESH;
    localparam logic [31:0]        MIN_COUNT = MIN_PERIOD;
    localparam logic [31:0]        MAX_COUNT = MAX_PERIOD;
    localparam logic [32:0]        TOL_DIFF  = 33'(TOL);

    state_t      state;
    state_t      state_next;
    logic        sign;
    logic        sign_next;
    logic [31:0] count;
    logic [31:0] count_next;
    logic [31:0] last_period;
    logic [31:0] last_period_next;
    logic [31:0] period_next;
    logic        period_valid_next;
    logic        note_present_next;
    logic        locked_next;

    logic        is_pos;
    logic        is_neg;
    logic        rising;
    logic [32:0] diff;
    logic        within_tol;

    // sign is 1 for POS, 0 for NEG; band samples never touch it
    assign is_pos = $signed(audio_in) > POS_LIMIT;
    assign is_neg = $signed(audio_in) < NEG_LIMIT;
    assign rising = is_pos && !sign;

    always_comb begin
        if (count >= last_period) begin
            diff = {1'b0, count} - {1'b0, last_period};
        end else begin
            diff = {1'b0, last_period} - {1'b0, count};
        end
    end

    assign within_tol = (diff <= TOL_DIFF);

    always_comb begin
        state_next        = state;
        sign_next         = sign;
        count_next        = count;
        last_period_next  = last_period;
        period_next       = period;
        period_valid_next = 1'b0;
        note_present_next = note_present;
        locked_next       = locked;

        if (sample_en) begin
            if (is_pos) begin
                sign_next = 1'b1;
            end else if (is_neg) begin
                sign_next = 1'b0;
            end

            case (state)
                IDLE: begin
                    if (is_pos || is_neg) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (rising) begin
                        count_next = 32'd1;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    // an accepted event wins over a timeout on the same sample
                    if (rising && (count >= MIN_COUNT)) begin
                        period_next       = count;
                        last_period_next  = count;
                        count_next        = 32'd1;
                        period_valid_next = 1'b1;
                        note_present_next = 1'b1;
                        locked_next       = note_present && within_tol;
                    end else if (count < MAX_COUNT) begin
                        count_next = count + 32'd1;
                    end else begin
                        state_next        = IDLE;
                        count_next        = 32'd0;
                        period_next       = 32'd0;
                        last_period_next  = 32'd0;
                        note_present_next = 1'b0;
                        locked_next       = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            sign         <= 1'b0;
            count        <= 32'd0;
            last_period  <= 32'd0;
            period       <= 32'd0;
            period_valid <= 1'b0;
            note_present <= 1'b0;
            locked       <= 1'b0;
        end else begin
            state        <= state_next;
            sign         <= sign_next;
            count        <= count_next;
            last_period  <= last_period_next;
            period       <= period_next;
            period_valid <= period_valid_next;
            note_present <= note_present_next;
            locked       <= locked_next;
        end
    end

endmodule

// File: tb/tb_square_period_detector.sv
// Directed bench for square_period_detector: square waves of known period,
// glitches, band noise, timeout, sample gating and asynchronous reset.
module tb_square_period_detector;

    localparam int MAX_P = 1100;
    localparam logic [31:0] HI      = 32'sd300000000;
    localparam logic [31:0] LO      = -32'sd300000000;
    localparam logic [31:0] BAND_HI = 32'sd50000000;
    localparam logic [31:0] BAND_LO = -32'sd50000000;
    localparam logic [31:0] ZERO    = 32'd0;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        sample_en = 1'b0;
    logic [31:0] audio_in = 32'd0;
    logic [31:0] period;
    logic        period_valid;
    logic        note_present;
    logic        locked;

    int          vectors = 0;
    int          miscompares = 0;
    int          pulse_count = 0;
    logic [31:0] seen_period = 32'd0;
    logic        seen_locked = 1'b0;
    logic        seen_np = 1'b0;
    logic        prev_pv = 1'b0;

    square_period_detector #(
        .THRESH     (100000000),
        .MIN_PERIOD (16),
        .MAX_PERIOD (MAX_P),
        .TOL        (4)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .sample_en    (sample_en),
        .audio_in     (audio_in),
        .period       (period),
        .period_valid (period_valid),
        .note_present (note_present),
        .locked       (locked)
    );

    always #5 clock = ~clock;

    // Records every period_valid pulse and flags back-to-back pulses
    always @(posedge clock) begin
        #1;
        if (period_valid) begin
            pulse_count = pulse_count + 1;
            seen_period = period;
            seen_locked = locked;
            seen_np     = note_present;
            vectors     = vectors + 1;
            assert (prev_pv === 1'b0) else begin
                miscompares = miscompares + 1;
                $error("[TB] FAIL pulse_back_to_back observed=%0b expected=0", prev_pv);
            end
        end
        prev_pv = period_valid;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected) else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives n samples; when gated, each valid sample is followed by a
    // disabled cycle carrying the opposite value, which must be ignored.
    task automatic apply_stimulus(input logic [31:0] value, input int n, input bit gated);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sample_en = 1'b1;
            audio_in  = value;
            if (gated) begin
                @(negedge clock);
                sample_en = 1'b0;
                audio_in  = 32'd0 - value;
            end
        end
    endtask

    task automatic wave(input int hi_len, input int lo_len, input int cycles, input bit gated);
        for (int c = 0; c < cycles; c++) begin
            apply_stimulus(HI, hi_len, gated);
            apply_stimulus(LO, lo_len, gated);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_output("reset_period", period, 32'd0);
        check_output("reset_valid", {31'd0, period_valid}, 32'd0);
        check_output("reset_note", {31'd0, note_present}, 32'd0);
        check_output("reset_locked", {31'd0, locked}, 32'd0);
        resetn = 1'b1;

        // 500/500 wave: arm, first measurement, then lock
        wave(500, 500, 2, 1'b0);
        check_output("first_edge_no_pulse", pulse_count, 0);
        wave(500, 500, 1, 1'b0);
        check_output("second_edge_pulses", pulse_count, 1);
        check_output("second_edge_period", seen_period, 32'd1000);
        check_output("second_edge_note", {31'd0, seen_np}, 32'd1);
        check_output("second_edge_locked", {31'd0, seen_locked}, 32'd0);
        wave(500, 500, 1, 1'b0);
        check_output("third_edge_pulses", pulse_count, 2);
        check_output("third_edge_locked", {31'd0, seen_locked}, 32'd1);
        check_output("period_held", period, 32'd1000);
        check_output("valid_is_pulse", {31'd0, period_valid}, 32'd0);

        // drift to 1002 keeps lock
        wave(501, 501, 2, 1'b0);
        check_output("drift_pulses", pulse_count, 4);
        check_output("drift_period", seen_period, 32'd1002);
        check_output("drift_locked", {31'd0, seen_locked}, 32'd1);

        // jump to 1010 drops lock once
        wave(505, 505, 2, 1'b0);
        check_output("jump_period", seen_period, 32'd1010);
        check_output("jump_unlocked", {31'd0, seen_locked}, 32'd0);
        wave(505, 505, 1, 1'b0);
        check_output("jump_relocked", {31'd0, seen_locked}, 32'd1);
        check_output("jump_pulses", pulse_count, 7);

        // glitch: a short negative dip gives a rising event at count 6
        apply_stimulus(HI, 5, 1'b0);
        apply_stimulus(LO, 1, 1'b0);
        apply_stimulus(HI, 494, 1'b0);
        apply_stimulus(LO, 500, 1'b0);
        check_output("glitch_ignored_pulses", pulse_count, 8);
        wave(500, 500, 1, 1'b0);
        check_output("after_glitch_period", seen_period, 32'd1000);
        check_output("after_glitch_unlocked", {31'd0, seen_locked}, 32'd0);
        wave(500, 500, 1, 1'b0);
        check_output("after_glitch_relocked", {31'd0, seen_locked}, 32'd1);

        // band noise then silence: timeout lands on the 1100th sample after the event
        apply_stimulus(HI, 500, 1'b0);
        for (int k = 0; k < 150; k++) begin
            apply_stimulus(BAND_HI, 1, 1'b0);
            apply_stimulus(BAND_LO, 1, 1'b0);
        end
        apply_stimulus(ZERO, 301, 1'b0);
        check_output("band_no_events", pulse_count, 11);
        check_output("pre_timeout_note", {31'd0, note_present}, 32'd1);
        check_output("pre_timeout_locked", {31'd0, locked}, 32'd1);
        apply_stimulus(ZERO, 1, 1'b0);
        check_output("timeout_note", {31'd0, note_present}, 32'd0);
        check_output("timeout_locked", {31'd0, locked}, 32'd0);
        check_output("timeout_period", period, 32'd0);

        // re-acquire with period exactly MAX_P: accepted, not timed out
        wave(550, 550, 2, 1'b0);
        check_output("reacquire_no_pulse", pulse_count, 11);
        wave(550, 550, 1, 1'b0);
        check_output("max_period_pulses", pulse_count, 12);
        check_output("max_period_value", seen_period, 32'd1100);
        check_output("max_period_note", {31'd0, seen_np}, 32'd1);
        check_output("max_period_locked", {31'd0, seen_locked}, 32'd0);

        // sample_en every other cycle: period counts samples, not clocks
        wave(500, 500, 2, 1'b1);
        check_output("gated_pulses", pulse_count, 14);
        check_output("gated_period", seen_period, 32'd1000);
        check_output("gated_unlocked", {31'd0, seen_locked}, 32'd0);
        wave(500, 500, 1, 1'b1);
        check_output("gated_relocked", {31'd0, seen_locked}, 32'd1);

        // asynchronous reset mid-period, checked before any clock edge
        apply_stimulus(HI, 200, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check_output("async_period", period, 32'd0);
        check_output("async_note", {31'd0, note_present}, 32'd0);
        check_output("async_locked", {31'd0, locked}, 32'd0);
        check_output("async_valid", {31'd0, period_valid}, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        wave(500, 500, 2, 1'b0);
        check_output("post_reset_no_pulse", pulse_count, 16);
        wave(500, 500, 1, 1'b0);
        check_output("post_reset_pulses", pulse_count, 17);
        check_output("post_reset_period", seen_period, 32'd1000);
        check_output("post_reset_locked", {31'd0, seen_locked}, 32'd0);

        // MIN_PERIOD boundary: event at count 15 ignored, at count 16 accepted
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        apply_stimulus(LO, 20, 1'b0);
        apply_stimulus(HI, 8, 1'b0);
        apply_stimulus(LO, 7, 1'b0);
        apply_stimulus(HI, 1, 1'b0);
        apply_stimulus(LO, 24, 1'b0);
        check_output("min_count15_ignored", pulse_count, 17);
        apply_stimulus(HI, 8, 1'b0);
        check_output("min_first_pulse", pulse_count, 18);
        check_output("min_first_period", seen_period, 32'd40);
        apply_stimulus(LO, 8, 1'b0);
        apply_stimulus(HI, 3, 1'b0);
        check_output("min_count16_pulses", pulse_count, 19);
        check_output("min_count16_period", seen_period, 32'd16);
        check_output("min_count16_locked", {31'd0, seen_locked}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
